dvs_fifo_bus_arbiter: RTL and testbench



---
 rtl/dvs_fifo_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_dvs_fifo_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvs_fifo_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dvs_fifo_bus_arbiter
//
// Round-robin arbiter and write-port multiplexer for the shared event FIFO bus.
// Each event interface raises req and receives a one-cycle grant. On the
// following cycle the granted interface drives its wr_en_in/event_in lane,
// which is forwarded to the FIFO write port. Grants are withheld while the
// FIFO is full. The block also counts committed writes and latches a sticky
// protocol-error flag.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   arb_en       arbitration enable (0 = issue no new grants)
//   req          per-interface write request
//   grant        one-hot, one-cycle grant (registered)
//   wr_en_in     per-interface write enable
//   event_in     per-interface event words, lane i at [i*EVENT_W +: EVENT_W]
//   fifo_full    FIFO full flag
//   fifo_wr_en   FIFO write strobe
//   fifo_wdata   FIFO write data
//   write_count  committed FIFO writes, wraps modulo 2^CNT_BITS
//   proto_err    sticky protocol-violation flag, cleared only by rst
// -----------------------------------------------------------------------------
module dvs_fifo_bus_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int EVENT_W  = 16,   // event word width (EVENT_BITS in the system package)
   parameter int CNT_BITS = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         arb_en,
   input  logic [NUM_REQ-1:0]           req,
   output logic [NUM_REQ-1:0]           grant,
   input  logic [NUM_REQ-1:0]           wr_en_in,
   input  logic [NUM_REQ*EVENT_W-1:0]   event_in,
   input  logic                         fifo_full,
   output logic                         fifo_wr_en,
   output logic [EVENT_W-1:0]           fifo_wdata,
   output logic [CNT_BITS-1:0]          write_count,
   output logic                         proto_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   gnt_idx;

   logic [IDX_W-1:0]   sel;
   logic [IDX_W-1:0]   cand;
   logic               found;
   logic [EVENT_W-1:0] ev [NUM_REQ];
   logic [NUM_REQ-1:0] exp_mask;
   logic               missed_wr;
   logic               unsol_wr;

   // Round-robin search starting just after the last winner.
   always_comb begin
      sel   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   // Unpack the flattened event lanes.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         ev[i] = event_in[i*EVENT_W +: EVENT_W];
      end
   end

   // Only the granted lane may write, and only during its WAIT cycle.
   always_comb begin
      exp_mask = '0;
      if (state == ST_WAIT) begin
         exp_mask[gnt_idx] = 1'b1;
      end
   end

   assign missed_wr = (state == ST_WAIT) && !wr_en_in[gnt_idx];
   assign unsol_wr  = |(wr_en_in & ~exp_mask);

   // A reset landing in the WAIT cycle abandons the pending write.
   assign fifo_wr_en = (state == ST_WAIT) && !rst && wr_en_in[gnt_idx];
   assign fifo_wdata = ev[gnt_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_ARB;
         grant       <= '0;
         rr_ptr      <= IDX_W'(NUM_REQ - 1);
         gnt_idx     <= '0;
         write_count <= '0;
         proto_err   <= 1'b0;
      end else begin
         grant <= '0;
         case (state)
            ST_ARB: begin
               // No write is in flight here, so fifo_full is exact.
               if (arb_en && !fifo_full && found) begin
                  grant   <= NUM_REQ'(1) << sel;
                  gnt_idx <= sel;
                  rr_ptr  <= sel;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               state <= ST_ARB;
            end
            default: begin
               state <= ST_ARB;
            end
         endcase

         if (fifo_wr_en) begin
            write_count <= write_count + CNT_BITS'(1);
         end

         if (missed_wr || unsol_wr) begin
            proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dvs_fifo_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dvs_fifo_bus_arbiter
//
// Self-checking bench for dvs_fifo_bus_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_dvs_fifo_bus_arbiter;

   localparam int NUM_REQ  = 4;
   localparam int EVENT_W  = 16;
   localparam int CNT_BITS = 32;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       arb_en;
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ-1:0]         grant;
   logic [NUM_REQ-1:0]         wr_en_in;
   logic [NUM_REQ*EVENT_W-1:0] event_in;
   logic                       fifo_full;
   logic                       fifo_wr_en;
   logic [EVENT_W-1:0]         fifo_wdata;
   logic [CNT_BITS-1:0]        write_count;
   logic                       proto_err;

   dvs_fifo_bus_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .EVENT_W  (EVENT_W),
      .CNT_BITS (CNT_BITS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .arb_en      (arb_en),
      .req         (req),
      .grant       (grant),
      .wr_en_in    (wr_en_in),
      .event_in    (event_in),
      .fifo_full   (fifo_full),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_wdata  (fifo_wdata),
      .write_count (write_count),
      .proto_err   (proto_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: which requester owns the write slot this cycle, the
   // last winner, and the observable results.
   int                  m_pending;
   int                  m_last;
   logic [CNT_BITS-1:0] m_cnt;
   logic                m_err;
   logic [NUM_REQ-1:0]  m_grant;
   logic                m_wr_en;
   logic [EVENT_W-1:0]  m_wdata;

   // Combinational outputs captured mid-cycle, before the clock edge.
   logic                obs_wr_en;
   logic [EVENT_W-1:0]  obs_wdata;

   task automatic model_reset();
      m_pending = -1;
      m_last    = NUM_REQ - 1;
      m_cnt     = '0;
      m_err     = 1'b0;
      m_grant   = '0;
      m_wr_en   = 1'b0;
      m_wdata   = '0;
   endtask

   // One clock cycle: drive inputs, sample combinational outputs, advance the
   // model over the edge, then step to just after the edge.
   task automatic cycle(input logic r, input logic en, input logic full,
                        input logic [NUM_REQ-1:0] rq, input logic [NUM_REQ-1:0] wr,
                        input logic [NUM_REQ*EVENT_W-1:0] ev);
      int nxt;
      rst = r; arb_en = en; fifo_full = full; req = rq; wr_en_in = wr; event_in = ev;
      #3;
      obs_wr_en = fifo_wr_en;
      obs_wdata = fifo_wdata;
      if (r) begin
         model_reset();
      end else begin
         m_wr_en = (m_pending >= 0) && wr[m_pending];
         m_wdata = (m_pending >= 0) ? ev[m_pending*EVENT_W +: EVENT_W] : '0;
         if ((m_pending >= 0) && !wr[m_pending]) m_err = 1'b1;
         for (int j = 0; j < NUM_REQ; j++)
            if (wr[j] && (j != m_pending)) m_err = 1'b1;
         if (m_wr_en) m_cnt = m_cnt + 1;
         m_grant = '0;
         nxt     = -1;
         if ((m_pending < 0) && en && !full && (rq != 0)) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               int c;
               c = (m_last + k) % NUM_REQ;
               if (rq[c]) begin
                  nxt = c;
                  break;
               end
            end
            m_grant[nxt] = 1'b1;
            m_last       = nxt;
         end
         m_pending = nxt;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b0, 1'b0, '0, '0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0, '0, '0);
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
      n_cmp++; if (write_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", write_count); end
      n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", proto_err); end
      n_cmp++; if (obs_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", obs_wr_en); end
   endtask

   task automatic test_single_write();
      logic [NUM_REQ*EVENT_W-1:0] ev;
      cycle(1'b1, 1'b1, 1'b0, '0, '0, '0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);
         n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL idle_grant: got %b want 0000", grant); end
      end
      cycle(1'b0, 1'b1, 1'b0, 4'b0001, '0, '0);
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", grant); end
      ev = '0;
      ev[15:0] = 16'h01A5;
      cycle(1'b0, 1'b1, 1'b0, '0, 4'b0001, ev);
      n_cmp++; if (obs_wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en: got %b want 1", obs_wr_en); end
      n_cmp++; if (obs_wdata !== 16'h01A5) begin n_err++; $display("FAIL single_wdata: got %h want 01a5", obs_wdata); end
      n_cmp++; if (write_count !== 32'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", write_count); end
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL single_no_regrant: got %b want 0000", grant); end
   endtask

   task automatic test_round_robin();
      logic [NUM_REQ-1:0] want;
      logic [NUM_REQ-1:0] wr;
      cycle(1'b1, 1'b1, 1'b0, '0, '0, '0);
      wr = '0;
      for (int i = 0; i < 17; i++) begin
         cycle(1'b0, 1'b1, 1'b0, (i < 16) ? 4'b1111 : 4'b0000, wr,
               {$urandom, $urandom});
         want = ((i % 2) == 0 && i < 16) ? (4'b0001 << ((i / 2) % 4)) : 4'b0000;
         n_cmp++; if (grant !== want) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, want); end
         wr = grant;
      end
      n_cmp++; if (write_count !== 32'd8) begin n_err++; $display("FAIL rr_count: got %0d want 8", write_count); end
      n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL rr_err: got %b want 0", proto_err); end
   endtask

   task automatic test_fifo_full();
      cycle(1'b1, 1'b1, 1'b0, '0, '0, '0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b1, 1'b1, 4'b0100, '0, '0);
         n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL full_block[%0d]: got %b want 0000", i, grant); end
      end
      cycle(1'b0, 1'b1, 1'b0, 4'b0100, '0, '0);
      n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL full_release: got %b want 0100", grant); end
      cycle(1'b0, 1'b1, 1'b0, '0, 4'b0100, '0);
      n_cmp++; if (write_count !== 32'd1) begin n_err++; $display("FAIL full_count: got %0d want 1", write_count); end
   endtask

   task automatic test_missed_write();
      cycle(1'b1, 1'b1, 1'b0, '0, '0, '0);
      cycle(1'b0, 1'b1, 1'b0, 4'b0001, '0, '0);
      cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);
      n_cmp++; if (obs_wr_en !== 1'b0) begin n_err++; $display("FAIL missed_wr_en: got %b want 0", obs_wr_en); end
      n_cmp++; if (write_count !== 32'd0) begin n_err++; $display("FAIL missed_count: got %0d want 0", write_count); end
      n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL missed_err: got %b want 1", proto_err); end
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, '0);
      n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL missed_err_sticky: got %b want 1", proto_err); end
      cycle(1'b1, 1'b0, 1'b0, '0, '0, '0);
      n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL missed_err_clear: got %b want 0", proto_err); end
   endtask

   task automatic test_unsolicited();
      cycle(1'b1, 1'b1, 1'b0, '0, '0, '0);
      cycle(1'b0, 1'b1, 1'b0, '0, 4'b1000, {4{16'hBEEF}});
      n_cmp++; if (obs_wr_en !== 1'b0) begin n_err++; $display("FAIL unsol_wr_en: got %b want 0", obs_wr_en); end
      n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL unsol_err: got %b want 1", proto_err); end
      n_cmp++; if (write_count !== 32'd0) begin n_err++; $display("FAIL unsol_count: got %0d want 0", write_count); end
      cycle(1'b1, 1'b1, 1'b0, '0, '0, '0);
      n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL unsol_rst_err: got %b want 0", proto_err); end
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL unsol_rst_grant: got %b want 0000", grant); end
   endtask

   task automatic test_arb_en();
      cycle(1'b1, 1'b0, 1'b0, '0, '0, '0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 4'b0011, '0, '0);
         n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL en_off[%0d]: got %b want 0000", i, grant); end
      end
      cycle(1'b0, 1'b1, 1'b0, 4'b0011, '0, '0);
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL en_grant0: got %b want 0001", grant); end
      cycle(1'b0, 1'b1, 1'b0, 4'b0010, 4'b0001, '0);
      cycle(1'b0, 1'b1, 1'b0, 4'b0011, '0, '0);
      n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL en_grant1: got %b want 0010", grant); end
      cycle(1'b0, 1'b0, 1'b0, 4'b0011, 4'b0010, {4{16'h0C3C}});
      n_cmp++; if (obs_wr_en !== 1'b1) begin n_err++; $display("FAIL en_drop_wr_en: got %b want 1", obs_wr_en); end
      n_cmp++; if (write_count !== 32'd2) begin n_err++; $display("FAIL en_drop_count: got %0d want 2", write_count); end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 4'b0011, '0, '0);
         n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL en_drop_nogrant[%0d]: got %b want 0000", i, grant); end
      end
   endtask

   task automatic test_reset_mid_wait();
      cycle(1'b1, 1'b1, 1'b0, '0, '0, '0);
      cycle(1'b0, 1'b1, 1'b0, 4'b0100, '0, '0);
      cycle(1'b1, 1'b1, 1'b0, '0, 4'b0100, {4{16'h5A5A}});
      n_cmp++; if (obs_wr_en !== 1'b0) begin n_err++; $display("FAIL rstwait_wr_en: got %b want 0", obs_wr_en); end
      n_cmp++; if (write_count !== 32'd0) begin n_err++; $display("FAIL rstwait_count: got %0d want 0", write_count); end
      // Requester 0 wins first again after reset.
      cycle(1'b0, 1'b1, 1'b0, 4'b0101, '0, '0);
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL rstwait_first: got %b want 0001", grant); end
   endtask

   task automatic test_random();
      logic [NUM_REQ-1:0] wr;
      logic               en, full;
      cycle(1'b1, 1'b1, 1'b0, '0, '0, '0);
      wr = '0;
      for (int i = 0; i < 400; i++) begin
         en   = ($urandom_range(0, 9) != 0);
         full = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 49) == 0) wr = NUM_REQ'($urandom);
         cycle((i == 200), en, full, NUM_REQ'($urandom), wr, {$urandom, $urandom});
         n_cmp++; if (grant !== m_grant) begin n_err++; $display("FAIL rand_grant[%0d]: got %b want %b", i, grant, m_grant); end
         n_cmp++; if (obs_wr_en !== m_wr_en) begin n_err++; $display("FAIL rand_wr_en[%0d]: got %b want %b", i, obs_wr_en, m_wr_en); end
         if (m_wr_en) begin
            n_cmp++; if (obs_wdata !== m_wdata) begin n_err++; $display("FAIL rand_wdata[%0d]: got %h want %h", i, obs_wdata, m_wdata); end
         end
         n_cmp++; if (write_count !== m_cnt) begin n_err++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, write_count, m_cnt); end
         n_cmp++; if (proto_err !== m_err) begin n_err++; $display("FAIL rand_err[%0d]: got %b want %b", i, proto_err, m_err); end
         wr = m_grant;
      end
   endtask

   initial begin
      model_reset();
      rst = 1'b1; arb_en = 1'b0; fifo_full = 1'b0; req = '0; wr_en_in = '0; event_in = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_single_write();
      test_round_robin();
      test_fifo_full();
      test_missed_write();
      test_unsolicited();
      test_arb_en();
      test_reset_mid_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
